dff_pipe: RTL and testbench
===========================

// Module: dff_pipe
// PURPOSE
//  Parametrised successor to the single D flip-flop: a WIDTH-bit, DEPTH-stage
//  D-register pipeline with per-stage valid bits, clock enable (stall), flush,
//  a runtime-selectable tap output and an occupancy count. Used as the
//  standard delay-line / retiming stage between datapath blocks.
// PARAMETERS
//  WIDTH    8   data width in bits (>=1)
//  DEPTH    4   number of register stages (>=1)
//  RST_VAL  0   WIDTH-bit reset value loaded into every data stage
//  TW       derived: (DEPTH>1) ? $clog2(DEPTH) : 1; width of tap_sel
//  CW       derived: $clog2(DEPTH+1); width of occ
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous reset, active-high
//  en         in   1      advance enable; 0 = hold all stages
//  flush      in   1      clear all valid bits (synchronous)
//  d          in   WIDTH  input data
//  d_vld      in   1      input data valid
//  tap_sel    in   TW     tap stage select (0 = first stage)
//  q          out  WIDTH  data of last stage, stage[DEPTH-1]
//  q_vld      out  1      valid of last stage
//  q_tap      out  WIDTH  data of stage[tap_sel]
//  q_tap_vld  out  1      valid of stage[tap_sel]
//  occ        out  CW     number of stages currently holding valid data
// BEHAVIOUR
//  - Every action takes effect at a rising edge of clk. Priority: rst > flush > en.
//  - rst=1: all data stages <= RST_VAL, all valids <= 0, occ <= 0. Clears any
//    in-flight data mid-operation; next edge after rst falls behaves normally.
//  - Reset values: q=RST_VAL, q_vld=0, q_tap=RST_VAL, q_tap_vld=0, occ=0.
//  - flush=1 (rst=0): all valids <= 0, occ <= 0; data stages hold their values;
//    d is NOT captured, even when en=1.
//  - en=1 (rst=0, flush=0): stage[0] <= {d,d_vld}; stage[i] <= stage[i-1] for
//    i=1..DEPTH-1. Data with d_vld=0 is shifted as a bubble (data moves,
//    valid=0). The old stage[DEPTH-1] is discarded.
//  - en=0 (rst=0, flush=0): all stages and occ hold.
//  - Latency: d sampled at an enabled edge appears on q after DEPTH enabled
//    edges; stall cycles (en=0) add latency 1:1. DEPTH=1 -> q after 1 edge.
//  - q, q_vld: driven directly from stage[DEPTH-1] registers (no comb path
//    from d).
//  - q_tap, q_tap_vld: combinational mux of stage registers by tap_sel;
//    tap_sel >= DEPTH selects stage[DEPTH-1]. No comb path from d/en/flush.
//  - occ: registered; on an enabled shift occ <= occ + d_vld - stage[DEPTH-1].vld;
//    must always equal the popcount of the valid bits; range 0..DEPTH, never
//    wraps (full pipe shifting in valid while valid leaves stays at DEPTH).
// TESTING
//  1 rst=1 two edges with en=1,d=8'hFF,d_vld=1 -> q=RST_VAL, q_vld=0, occ=0.
//  2 DEPTH=4, en=1, d=8'h11,8'h22,8'h33 (vld=1) on consecutive edges -> 8'h11
//    on q with q_vld=1 at 4th edge, then 8'h22, 8'h33; occ peaks at 3.
//  3 Load 8'hA5 valid, then en=0 for 5 cycles -> all stages/occ frozen; q
//    shows 8'hA5 exactly 3 enabled edges after en returns.
//  4 Full pipe (occ=4), assert flush with en=1,d=8'h77,d_vld=1 -> next edge
//    occ=0, q_vld=0, q_tap_vld=0 for all tap_sel, q data unchanged, 8'h77 lost.
//  5 Stream 8'h01..8'h04 valid, sweep tap_sel 0..3 (and 5 on DEPTH=6 build with
//    TW=3, sel=7 -> stage 5) -> q_tap matches stage contents, out-of-range
//    selects last stage.
//  6 Alternate d_vld 1/0 with en=1 for 10 edges, rst mid-stream -> occ tracks
//    popcount every cycle (2 when steady-state), rst returns all outputs to
//    reset values next edge.

Source files
------------

// File: rtl/dff_pipe.sv
// dff_pipe: WIDTH-bit, DEPTH-stage D-register delay line.
// Each stage carries a data word and a valid bit. The pipe supports stall,
// flush, a runtime-selectable tap and a registered occupancy count.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (highest priority)
//   en         advance enable; 0 holds every stage
//   flush      clears all valid bits; data registers keep their values
//   d, d_vld   input word and its valid bit, captured into stage 0
//   tap_sel    stage index for the tap output (>= DEPTH selects last stage)
//   q, q_vld   last stage, straight from its registers
//   q_tap      data of stage[tap_sel]; combinational from stage registers only
//   q_tap_vld  valid of stage[tap_sel]
//   occ        registered count of valid stages, 0..DEPTH
module dff_pipe #(
    parameter int unsigned       WIDTH   = 8,
    parameter int unsigned       DEPTH   = 4,
    parameter logic [WIDTH-1:0]  RST_VAL = '0,
    localparam int unsigned      TW      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned      CW      = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic [WIDTH-1:0] d,
    input  logic             d_vld,
    input  logic [TW-1:0]    tap_sel,
    output logic [WIDTH-1:0] q,
    output logic             q_vld,
    output logic [WIDTH-1:0] q_tap,
    output logic             q_tap_vld,
    output logic [CW-1:0]    occ
);

    logic [WIDTH-1:0] data_a [DEPTH];
    logic [DEPTH-1:0] vld_a;
    logic [CW-1:0]    occ_r;
    logic             tap_in_range;

    // One register pair per stage; stage 0 is fed from the input port.
    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        logic [WIDTH-1:0] d_in;
        logic             v_in;
        logic [WIDTH-1:0] data_q;
        logic             vld_q;

        if (g == 0) begin : g_head
            assign d_in = d;
            assign v_in = d_vld;
        end else begin : g_tail
            assign d_in = data_a[g-1];
            assign v_in = vld_a[g-1];
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                data_q <= RST_VAL;
                vld_q  <= 1'b0;
            end else if (flush) begin
                vld_q  <= 1'b0;
            end else if (en) begin
                data_q <= d_in;
                vld_q  <= v_in;
            end
        end

        assign data_a[g] = data_q;
        assign vld_a[g]  = vld_q;
    end

    // Occupancy: one in at stage 0, one out from the last stage. The modulo
    // arithmetic of the intermediate sum is harmless because the true result
    // always lies in 0..DEPTH.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            occ_r <= '0;
        end else if (en) begin
            occ_r <= occ_r + CW'(d_vld) - CW'(vld_a[DEPTH-1]);
        end
    end

    assign q     = data_a[DEPTH-1];
    assign q_vld = vld_a[DEPTH-1];
    assign occ   = occ_r;

    // Tap mux: selects above the last stage fold onto the last stage.
    assign tap_in_range = ({1'b0, tap_sel} < (TW + 1)'(DEPTH));

    always_comb begin
        q_tap     = data_a[DEPTH-1];
        q_tap_vld = vld_a[DEPTH-1];
        if (tap_in_range) begin
            q_tap     = data_a[tap_sel];
            q_tap_vld = vld_a[tap_sel];
        end
    end

endmodule

// File: tb/tb_dff_pipe.sv
// tb_dff_pipe: self-checking bench for dff_pipe (DEPTH=4 and DEPTH=6 builds).
// The reference model is a queue of {data, valid} entries per pipe:
// a shift is push_front + pop_back, occupancy is a popcount of the queue.
module tb_dff_pipe;

    localparam logic [7:0] R4 = 8'h00;
    localparam logic [7:0] R6 = 8'h3C;

    logic       clk = 1'b0;
    logic       rst, en, flush, d_vld;
    logic [7:0] d;
    logic [1:0] tap_sel;
    logic [2:0] tap_sel6;

    logic [7:0] q, q_tap, q6, q_tap6;
    logic       q_vld, q_tap_vld, q_vld6, q_tap_vld6;
    logic [2:0] occ, occ6;

    typedef struct packed {
        logic [7:0] d;
        logic       v;
    } ent_t;

    ent_t p4[$];
    ent_t p6[$];

    int checks = 0;
    int errors = 0;

    dff_pipe #(.WIDTH(8), .DEPTH(4), .RST_VAL(R4)) dut (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .d(d), .d_vld(d_vld),
        .tap_sel(tap_sel), .q(q), .q_vld(q_vld), .q_tap(q_tap),
        .q_tap_vld(q_tap_vld), .occ(occ)
    );

    dff_pipe #(.WIDTH(8), .DEPTH(6), .RST_VAL(R6)) dut6 (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .d(d), .d_vld(d_vld),
        .tap_sel(tap_sel6), .q(q6), .q_vld(q_vld6), .q_tap(q_tap6),
        .q_tap_vld(q_tap_vld6), .occ(occ6)
    );

    always #5 clk = ~clk;

    function automatic int pop4();
        int n = 0;
        foreach (p4[i]) n += int'(p4[i].v);
        return n;
    endfunction

    function automatic int pop6();
        int n = 0;
        foreach (p6[i]) n += int'(p6[i].v);
        return n;
    endfunction

    function automatic ent_t tap4(int s);
        return p4[(s < 4) ? s : 3];
    endfunction

    function automatic ent_t tap6(int s);
        return p6[(s < 6) ? s : 5];
    endfunction

    task automatic model_reset();
        p4.delete();
        p6.delete();
        repeat (4) p4.push_back('{d: R4, v: 1'b0});
        repeat (6) p6.push_back('{d: R6, v: 1'b0});
    endtask

    task automatic model_edge();
        ent_t e;
        if (rst) begin
            model_reset();
        end else if (flush) begin
            foreach (p4[i]) p4[i].v = 1'b0;
            foreach (p6[i]) p6[i].v = 1'b0;
        end else if (en) begin
            e = '{d: d, v: d_vld};
            p4.push_front(e);
            p6.push_front(e);
            void'(p4.pop_back());
            void'(p6.pop_back());
        end
    endtask

    // Advance one clock edge; outputs are settled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; flush = 1'b0; d = 8'hFF; d_vld = 1'b1;
        tap_sel = 2'd0; tap_sel6 = 3'd0;
        repeat (2) tick();
        checks++;
        if ({q, q_vld, occ} !== {R4, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL reset4 q/vld/occ got %h/%b/%0d want %h/0/0", q, q_vld, occ, R4);
        end
        checks++;
        if ({q_tap, q_tap_vld} !== {R4, 1'b0}) begin
            errors++;
            $display("FAIL reset4 tap got %h/%b want %h/0", q_tap, q_tap_vld, R4);
        end
        checks++;
        if ({q6, q_vld6, occ6, q_tap6, q_tap_vld6} !== {R6, 1'b0, 3'd0, R6, 1'b0}) begin
            errors++;
            $display("FAIL reset6 got q=%h v=%b occ=%0d tap=%h/%b want %h/0/0", q6, q_vld6, occ6,
                     q_tap6, q_tap_vld6, R6);
        end
        rst = 1'b0;
    endtask

    task automatic test_latency();
        logic [2:0] max_occ = '0;
        logic [7:0] want;
        en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            d     = (k < 3) ? 8'(8'h11 * (k + 1)) : 8'($urandom);
            d_vld = (k < 3);
            tick();
            if (occ > max_occ) max_occ = occ;
            checks++;
            if ({q, q_vld, occ} !== {p4[3].d, p4[3].v, 3'(pop4())}) begin
                errors++;
                $display("FAIL latency k=%0d got q=%h v=%b occ=%0d want q=%h v=%b occ=%0d",
                         k, q, q_vld, occ, p4[3].d, p4[3].v, pop4());
            end
            if (k >= 3 && k <= 5) begin
                want = 8'(8'h11 * (k - 2));
                checks++;
                if ({q, q_vld} !== {want, 1'b1}) begin
                    errors++;
                    $display("FAIL latency_edge%0d got %h/%b want %h/1", k + 1, q, q_vld, want);
                end
            end
        end
        checks++;
        if (max_occ !== 3'd3) begin
            errors++;
            $display("FAIL latency_peak_occ got %0d want 3", max_occ);
        end
    endtask

    task automatic test_stall();
        logic [2:0] occ_snap;
        en = 1'b1; d = 8'hA5; d_vld = 1'b1;
        tick();
        occ_snap = 3'(pop4());
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            d = 8'($urandom); d_vld = 1'b1;
            tick();
            checks++;
            if ({q, q_vld, occ} !== {p4[3].d, p4[3].v, occ_snap} ||
                {q6, q_vld6, occ6} !== {p6[5].d, p6[5].v, 3'(pop6())}) begin
                errors++;
                $display("FAIL stall_hold k=%0d got q=%h v=%b occ=%0d want q=%h v=%b occ=%0d",
                         k, q, q_vld, occ, p4[3].d, p4[3].v, occ_snap);
            end
        end
        en = 1'b1; d_vld = 1'b0;
        for (int n = 1; n <= 3; n++) begin
            d = 8'($urandom);
            tick();
            checks++;
            if (n == 3 ? ({q, q_vld} !== {8'hA5, 1'b1}) : (q_vld !== p4[3].v)) begin
                errors++;
                $display("FAIL stall_release n=%0d got %h/%b want %h/%b", n, q, q_vld,
                         (n == 3) ? 8'hA5 : p4[3].d, (n == 3) ? 1'b1 : p4[3].v);
            end
        end
    endtask

    task automatic test_flush();
        logic [7:0] q_before;
        en = 1'b1; d_vld = 1'b1;
        repeat (4) begin
            d = 8'($urandom);
            tick();
        end
        checks++;
        if (occ !== 3'd4) begin
            errors++;
            $display("FAIL flush_full_occ got %0d want 4", occ);
        end
        q_before = q;
        flush = 1'b1; d = 8'h77; d_vld = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if ({q, q_vld, occ, occ6} !== {q_before, 1'b0, 3'd0, 3'd0}) begin
            errors++;
            $display("FAIL flush_state got q=%h v=%b occ=%0d occ6=%0d want q=%h v=0 occ=0 occ6=0",
                     q, q_vld, occ, occ6, q_before);
        end
        for (int s = 0; s < 4; s++) begin
            tap_sel = 2'(s);
            #1;
            checks++;
            if ({q_tap, q_tap_vld} !== {tap4(s).d, 1'b0}) begin
                errors++;
                $display("FAIL flush_tap sel=%0d got %h/%b want %h/0", s, q_tap, q_tap_vld,
                         tap4(s).d);
            end
        end
        d_vld = 1'b0;
        for (int k = 0; k < 4; k++) begin
            d = 8'($urandom);
            tick();
            checks++;
            if ({q, q_vld, occ} !== {p4[3].d, 1'b0, 3'd0}) begin
                errors++;
                $display("FAIL flush_drain k=%0d got %h/%b/%0d want %h/0/0", k, q, q_vld, occ,
                         p4[3].d);
            end
        end
    endtask

    task automatic test_tap();
        logic [7:0] want;
        en = 1'b1; d_vld = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            d = 8'(k);
            tick();
        end
        en = 1'b0;
        for (int s = 0; s < 4; s++) begin
            tap_sel = 2'(s);
            #1;
            want = 8'(4 - s);
            checks++;
            if ({q_tap, q_tap_vld} !== {want, 1'b1} || tap4(s).d !== want) begin
                errors++;
                $display("FAIL tap4 sel=%0d got %h/%b want %h/1", s, q_tap, q_tap_vld, want);
            end
        end
        en = 1'b1;
        for (int k = 5; k <= 6; k++) begin
            d = 8'(k);
            tick();
        end
        en = 1'b0;
        for (int s = 0; s < 8; s++) begin
            tap_sel6 = 3'(s);
            #1;
            want = (s < 6) ? 8'(6 - s) : 8'h01;
            checks++;
            if ({q_tap6, q_tap_vld6} !== {want, 1'b1} || tap6(s).d !== want) begin
                errors++;
                $display("FAIL tap6 sel=%0d got %h/%b want %h/1", s, q_tap6, q_tap_vld6, want);
            end
        end
    endtask

    task automatic test_alt_rst();
        en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            d = 8'($urandom); d_vld = (k % 2 == 0);
            tick();
            checks++;
            if (occ !== 3'(pop4()) || occ6 !== 3'(pop6()) || (k >= 3 && occ !== 3'd2)) begin
                errors++;
                $display("FAIL alt_occ k=%0d got occ=%0d occ6=%0d want %0d/%0d", k, occ, occ6,
                         pop4(), pop6());
            end
        end
        rst = 1'b1; d = 8'hFF; d_vld = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({q, q_vld, occ, q_tap, q_tap_vld} !== {R4, 1'b0, 3'd0, R4, 1'b0} ||
            {q6, q_vld6, occ6} !== {R6, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL alt_midrst got q=%h v=%b occ=%0d tap=%h/%b q6=%h occ6=%0d",
                     q, q_vld, occ, q_tap, q_tap_vld, q6, occ6);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 300; k++) begin
            rst      = ($urandom_range(39) == 0);
            flush    = ($urandom_range(14) == 0);
            en       = ($urandom_range(3) != 0);
            d        = 8'($urandom);
            d_vld    = 1'($urandom);
            tap_sel  = 2'($urandom);
            tap_sel6 = 3'($urandom);
            tick();
            checks++;
            if ({q, q_vld, occ, q_tap, q_tap_vld} !==
                {p4[3].d, p4[3].v, 3'(pop4()), tap4(int'(tap_sel)).d, tap4(int'(tap_sel)).v}) begin
                errors++;
                $display("FAIL rand4 k=%0d got q=%h v=%b occ=%0d tap=%h/%b want %h/%b/%0d/%h/%b",
                         k, q, q_vld, occ, q_tap, q_tap_vld, p4[3].d, p4[3].v, pop4(),
                         tap4(int'(tap_sel)).d, tap4(int'(tap_sel)).v);
            end
            checks++;
            if ({q6, q_vld6, occ6, q_tap6, q_tap_vld6} !==
                {p6[5].d, p6[5].v, 3'(pop6()), tap6(int'(tap_sel6)).d, tap6(int'(tap_sel6)).v}) begin
                errors++;
                $display("FAIL rand6 k=%0d got q=%h v=%b occ=%0d tap=%h/%b want %h/%b/%0d/%h/%b",
                         k, q6, q_vld6, occ6, q_tap6, q_tap_vld6, p6[5].d, p6[5].v, pop6(),
                         tap6(int'(tap_sel6)).d, tap6(int'(tap_sel6)).v);
            end
        end
        rst = 1'b0; flush = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_latency();
        test_stall();
        test_flush();
        test_tap();
        test_alt_rst();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
